// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
//   - INSTR_W / OPC_MSB / OPC_LSB : instruction word layout ([18:16] opcode,
//     [15:8] data1, [7:0] data2)
//   - seq_state_t                 : sequencer FSM state encoding
//   - opcode_of()                 : extracts the opcode field from a word
package instr_sequencer_pkg;

    localparam int INSTR_W = 19;
    localparam int OPC_MSB = 18;
    localparam int OPC_LSB = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_EXEC     = 3'd3,
        ST_HALT     = 3'd4
    } seq_state_t;

    function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Fetch and issue bus of the instruction sequencer.
//   imem_addr  : fetch address (sequencer -> memory)
//   imem_rd    : one-cycle fetch strobe (sequencer -> memory)
//   imem_data  : fetched word (memory -> sequencer)
//   imem_valid : imem_data valid (memory -> sequencer)
//   instr_out  : instruction held for the CU (sequencer -> execute)
//   exec_valid : instr_out ready to execute (sequencer -> execute)
//   exec_ready : execute path accepts (execute -> sequencer)
// Modports: master = sequencer side, slave = memory/execute side.
interface instr_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    import instr_sequencer_pkg::*;

    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_rd;
    logic [INSTR_W-1:0]  imem_data;
    logic                imem_valid;
    logic [INSTR_W-1:0]  instr_out;
    logic                exec_valid;
    logic                exec_ready;

    modport master (
        output imem_addr, imem_rd, instr_out, exec_valid,
        input  imem_data, imem_valid, exec_ready
    );

    modport slave (
        input  imem_addr, imem_rd, instr_out, exec_valid,
        output imem_data, imem_valid, exec_ready
    );

endinterface

// File: rtl/instr_sequencer_pc_counter.sv
// Program counter for the instruction sequencer.
//   clk, reset : clock and asynchronous active-high reset (loads RESET_PC)
//   load       : reload RESET_PC (has priority over inc)
//   inc        : advance by one, wrapping modulo 2**PC_WIDTH
//   pc         : registered program counter
module seq_pc_counter #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                inc,
    output logic [PC_WIDTH-1:0] pc
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    logic [PC_WIDTH-1:0] pc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else if (load) begin
            pc_reg <= RESET_PC;
        end else if (inc) begin
            // Natural overflow of the fixed-width add gives the wrap.
            pc_reg <= pc_reg + PC_ONE;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue controller ahead of the CU opcode decoder. Walks pc through
// instruction memory, captures each word and offers it to the execute path
// with a valid/ready handshake. One instruction in flight; stops on a HALT
// opcode (not issued) or after a stop request once the current one retires.
//   clk, reset : clock, asynchronous active-high reset
//   start      : start from RESET_PC (accepted in IDLE or HALT)
//   stop       : request a stop after the current instruction retires
//   bus        : fetch/issue bus (master side)
//   pc         : current program counter (also drives bus.imem_addr)
//   busy       : high in FETCH, WAIT_MEM and EXEC
//   halted     : high in HALT
//   retired    : saturating count of completed exec transfers
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [2:0]          HALT_OPCODE = 3'd7,
    parameter int                  CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    instr_sequencer_if.master    bus,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 busy,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    seq_state_t          state_reg;
    logic [INSTR_W-1:0]  instr_out_reg;
    logic                imem_rd_reg;
    logic                exec_valid_reg;
    logic                busy_reg;
    logic                halted_reg;
    logic [CNT_WIDTH-1:0] retired_reg;
    logic                stop_pend_reg;

    logic pc_load;
    logic pc_inc;

    // The pc register lives in the counter; these decodes line up with the
    // start and transfer transitions taken by the FSM below.
    assign pc_load = ((state_reg == ST_IDLE) || (state_reg == ST_HALT)) && start;
    assign pc_inc  = (state_reg == ST_EXEC) && bus.exec_ready;

    seq_pc_counter #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load),
        .inc   (pc_inc),
        .pc    (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            instr_out_reg  <= '0;
            imem_rd_reg    <= 1'b0;
            exec_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            halted_reg     <= 1'b0;
            retired_reg    <= '0;
            stop_pend_reg  <= 1'b0;
        end else begin
            // Fetch strobe is a single-cycle pulse unless re-armed below.
            imem_rd_reg <= 1'b0;

            // Stop only ever latches while busy; transitions below may clear it.
            if (busy_reg && stop) begin
                stop_pend_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        // A simultaneous stop is discarded: start wins.
                        state_reg     <= ST_FETCH;
                        retired_reg   <= '0;
                        stop_pend_reg <= 1'b0;
                        imem_rd_reg   <= 1'b1;
                        busy_reg      <= 1'b1;
                        halted_reg    <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    state_reg <= ST_WAIT_MEM;
                end

                ST_WAIT_MEM: begin
                    if (bus.imem_valid) begin
                        instr_out_reg <= bus.imem_data;
                        if (opcode_of(bus.imem_data) == HALT_OPCODE) begin
                            // HALT is captured but never offered; pc stays put.
                            state_reg  <= ST_HALT;
                            busy_reg   <= 1'b0;
                            halted_reg <= 1'b1;
                        end else begin
                            state_reg      <= ST_EXEC;
                            exec_valid_reg <= 1'b1;
                        end
                    end
                end

                ST_EXEC: begin
                    if (bus.exec_ready) begin
                        exec_valid_reg <= 1'b0;
                        if (retired_reg != CNT_MAX) begin
                            retired_reg <= retired_reg + CNT_ONE;
                        end
                        // A stop arriving on the transfer cycle still counts.
                        if (stop_pend_reg || stop) begin
                            state_reg     <= ST_IDLE;
                            busy_reg      <= 1'b0;
                            stop_pend_reg <= 1'b0;
                        end else begin
                            state_reg   <= ST_FETCH;
                            imem_rd_reg <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg      <= ST_IDLE;
                    imem_rd_reg    <= 1'b0;
                    exec_valid_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                    halted_reg     <= 1'b0;
                    stop_pend_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_addr  = pc;
    assign bus.imem_rd    = imem_rd_reg;
    assign bus.instr_out  = instr_out_reg;
    assign bus.exec_valid = exec_valid_reg;
    assign busy           = busy_reg;
    assign halted         = halted_reg;
    assign retired        = retired_reg;

endmodule
